// File: rtl/mu_pkg.sv
// Shared types and sizes for the mu_core matrix-multiply front end.
// The signed-coefficient datapath is selected with the MU_SIGNED_EN macro.
package mu_pkg;
    localparam int DATA_W  = 8;
    localparam int COEF_W  = 7;
    localparam int ACC_W   = 18;
    localparam int N_LANE  = 4;
    localparam int MAC_CYC = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        MAC,
        EMIT,
        WAIT
    } state_t;
endpackage

// File: rtl/mu_mac_lane.sv
// One output row of Y = A*X: multiply-accumulate of coefficient byte and X byte.
// MU_SIGNED_EN defined: 8-bit two's-complement coef; otherwise unsigned 7-bit coef.
module mu_mac_lane
    import mu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] coef,
    input  logic [DATA_W-1:0] x,
    output logic [ACC_W-1:0]  acc_nxt
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;

`ifdef MU_SIGNED_EN
    logic signed [DATA_W:0]  coef_s;
    logic signed [DATA_W:0]  x_s;
    logic signed [ACC_W-1:0] prod_s;

    assign coef_s   = {coef[DATA_W-1], coef};
    assign x_s      = {1'b0, x};
    assign prod_s   = ACC_W'(coef_s) * ACC_W'(x_s);
    assign prod_ext = prod_s;
`else
    localparam int PROD_W = COEF_W + DATA_W;
    logic [PROD_W-1:0] prod_u;
    logic              unused_coef_msb;

    assign unused_coef_msb = coef[DATA_W-1];
    assign prod_u   = PROD_W'(coef[COEF_W-1:0]) * PROD_W'(x);
    assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod_u};
`endif

    // Exposes the total including this cycle's term so the core can register
    // the final sum on the last MAC edge and present it alongside web.
    assign acc_nxt = acc + prod_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc_nxt;
        end
    end
endmodule

// File: rtl/mu_core.sv
// Matrix-multiply front end: Y = A*X column by column, one web strobe per column.
// Optional signed coefficients via MU_SIGNED_EN (handled inside mu_mac_lane).
//
// state | meaning
// IDLE  | wait for start; done pulses here for one cycle after a job
// FETCH | in_addr presents column j to the input RAM
// LATCH | capture X column, clear accumulators, rom_addr = 0
// MAC   | four accumulate cycles, k = 0..3
// EMIT  | web high, MU1..MU4 valid
// WAIT  | WB_GAP idle cycles so writeback can finish its RAM writes
module mu_core
    import mu_pkg::*;
#(
    parameter int N_COL   = 4,
    parameter int IN_BASE = 0,
    parameter int WB_GAP  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        in_addr,
    input  logic [31:0]       in_data,
    output logic [1:0]        rom_addr,
    input  logic [31:0]       rom_data,
    output logic              web,
    output logic [ACC_W-1:0]  MU1,
    output logic [ACC_W-1:0]  MU2,
    output logic [ACC_W-1:0]  MU3,
    output logic [ACC_W-1:0]  MU4
);
    localparam logic [7:0] IN_B    = 8'(IN_BASE);
    localparam logic [5:0] J_LAST  = 6'(N_COL - 1);
    localparam logic [7:0] WAIT_LD = 8'(WB_GAP - 1);
    localparam logic [1:0] K_LAST  = 2'(MAC_CYC - 1);

    state_t                      state;
    logic [1:0]                  k;
    logic [5:0]                  j;
    logic [5:0]                  j_inc;
    logic [7:0]                  wait_cnt;
    logic [N_LANE-1:0][DATA_W-1:0] xcol;
    logic [N_LANE-1:0][ACC_W-1:0]  mu;
    logic [N_LANE-1:0][ACC_W-1:0]  acc_nxt;
    logic                        lane_clear;
    logic                        lane_en;

    assign j_inc      = j + 6'd1;
    assign lane_clear = (state == LATCH);
    assign lane_en    = (state == MAC);

    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        mu_mac_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (lane_clear),
            .enable  (lane_en),
            .coef    (rom_data[i*DATA_W +: DATA_W]),
            .x       (xcol[k]),
            .acc_nxt (acc_nxt[i])
        );
    end

    assign MU1 = mu[0];
    assign MU2 = mu[1];
    assign MU3 = mu[2];
    assign MU4 = mu[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            k        <= '0;
            j        <= '0;
            wait_cnt <= '0;
            xcol     <= '0;
            mu       <= '0;
            in_addr  <= '0;
            rom_addr <= '0;
            web      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            web  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        j       <= '0;
                        busy    <= 1'b1;
                        in_addr <= IN_B;
                    end
                end
                FETCH: begin
                    state    <= LATCH;
                    rom_addr <= '0;
                end
                LATCH: begin
                    state    <= MAC;
                    xcol     <= in_data;
                    k        <= '0;
                    rom_addr <= 2'd1;
                end
                MAC: begin
                    // ROM is one cycle ahead of k; the wrap on the last cycle is harmless.
                    rom_addr <= k + 2'd2;
                    if (k == K_LAST) begin
                        state <= EMIT;
                        web   <= 1'b1;
                        mu    <= acc_nxt;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                EMIT: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_LD;
                end
                WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        if (j == J_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            j       <= j_inc;
                            in_addr <= IN_B + {2'b00, j_inc};
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mu_core.sv
// Scoreboard bench for mu_core: stimulus pushes expected columns, a monitor checks on web/done.
module tb_mu_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, web;
    logic [7:0]  in_addr;
    logic [31:0] in_data;
    logic [1:0]  rom_addr;
    logic [31:0] rom_data;
    logic [17:0] MU1, MU2, MU3, MU4;

    always #5 clk = ~clk;

    mu_core dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .web      (web),
        .MU1      (MU1),
        .MU2      (MU2),
        .MU3      (MU3),
        .MU4      (MU4)
    );

    logic [31:0] rom [4];
    logic [31:0] ram [256];

    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        in_data  <= ram[in_addr];
    end

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int t0 = 0;
    int tests = 0;
    int fails = 0;
    int web_cnt = 0;
    int last_web = -1;

    typedef struct {
        int          cyc;
        logic [17:0] m0, m1, m2, m3;
    } col_t;
    typedef struct {
        int         cyc;
        logic [7:0] a;
    } fa_t;

    col_t sb[$];
    int   dq[$];
    fa_t  fq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        int   rel;
        col_t e;
        if (rst) begin
            rel = ecnt - t0;
            if (web) begin
                web_cnt++;
                if (last_web >= 0) check("web_spacing_ok", 32'(ecnt - last_web >= 4), 32'd1);
                last_web = ecnt;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_web: web high at cycle %0d, none expected", rel);
                end else begin
                    e = sb.pop_front();
                    check("web_cycle", 32'(rel), 32'(e.cyc));
                    check("MU1", 32'(MU1), 32'(e.m0));
                    check("MU2", 32'(MU2), 32'(e.m1));
                    check("MU3", 32'(MU3), 32'(e.m2));
                    check("MU4", 32'(MU4), 32'(e.m3));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done high at cycle %0d, none expected", rel);
                end else begin
                    check("done_cycle", 32'(rel), 32'(dq.pop_front()));
                end
            end
            if (fq.size() > 0 && fq[0].cyc == rel) begin
                check("in_addr_fetch", 32'(in_addr), 32'(fq[0].a));
                void'(fq.pop_front());
            end
        end
    end

    task automatic push_col(input int cyc, input logic [17:0] a, input logic [17:0] b,
                            input logic [17:0] c, input logic [17:0] d);
        col_t e;
        e.cyc = cyc; e.m0 = a; e.m1 = b; e.m2 = c; e.m3 = d;
        sb.push_back(e);
    endtask

    task automatic push_fetch(input int base);
        fa_t f;
        for (int j = 0; j < 4; j++) begin
            f.cyc = base + 1 + 10*j;
            f.a   = 8'(j);
            fq.push_back(f);
        end
        dq.push_back(base + 41);
    endtask

    task automatic push_identity(input int base);
        for (int j = 0; j < 4; j++)
            push_col(base + 7 + 10*j, 18'(4*j), 18'(4*j+1), 18'(4*j+2), 18'(4*j+3));
        push_fetch(base);
    endtask

    task automatic push_const(input logic [17:0] a, input logic [17:0] b,
                              input logic [17:0] c, input logic [17:0] d);
        for (int j = 0; j < 4; j++) push_col(7 + 10*j, a, b, c, d);
        push_fetch(0);
    endtask

    task automatic start_job();
        @(negedge clk);
        t0 = ecnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || dq.size() != 0 || fq.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d web, %0d done, %0d fetch expectations left", sb.size(), dq.size(), fq.size());
            sb.delete(); dq.delete(); fq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic load_identity();
        rom[0] = 32'h0000_0001;
        rom[1] = 32'h0000_0100;
        rom[2] = 32'h0001_0000;
        rom[3] = 32'h0100_0000;
        for (int j = 0; j < 256; j++)
            ram[j] = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
    endtask

    task automatic load_const(input logic [31:0] a, input logic [31:0] x);
        for (int k = 0; k < 4; k++) rom[k] = a;
        for (int j = 0; j < 256; j++) ram[j] = x;
    endtask

    logic [17:0] exp_ff;
    logic [17:0] exp_mix [4];

    initial begin
`ifdef MU_SIGNED_EN
        exp_ff     = 18'h3FC04;
        exp_mix[0] = -18'sd1270;
        exp_mix[1] = -18'sd1260;
        exp_mix[2] = -18'sd1250;
        exp_mix[3] = -18'sd1240;
`else
        exp_ff     = 18'h1FA04;
        exp_mix[0] = 18'd10;
        exp_mix[1] = 18'd20;
        exp_mix[2] = 18'd30;
        exp_mix[3] = 18'd40;
`endif
        load_identity();
        repeat (2) @(negedge clk);
        check("rst_web", 32'(web), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_MU1", 32'(MU1), 32'd0);
        check("rst_MU4", 32'(MU4), 32'd0);
        check("rst_in_addr", 32'(in_addr), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Identity A: MU equals the X column bytes.
        push_identity(0);
        start_job();
        wait_idle();

        // Full-scale unsigned: 127*255*4, busy high exactly cycles 1..40.
        load_const(32'h7F7F_7F7F, 32'hFFFF_FFFF);
        push_const(18'h1FA04, 18'h1FA04, 18'h1FA04, 18'h1FA04);
        @(negedge clk);
        t0 = ecnt;
        start = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check("busy_window", 32'(busy), 32'(c <= 40));
        end
        wait_idle();

        // Coefficient bit 7 set on every byte: masked unsigned, negative signed.
        load_const(32'h8483_8281, 32'h0403_0201);
        push_const(exp_mix[0], exp_mix[1], exp_mix[2], exp_mix[3]);
        start_job();
        wait_idle();

        // start pulsed while busy in column 1 must be ignored.
        load_identity();
        web_cnt = 0;
        push_identity(0);
        start_job();
        repeat (11) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("web_count", 32'(web_cnt), 32'd4);

        // Reset during MAC of column 2, then a clean job.
        push_identity(0);
        start_job();
        repeat (23) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_web", 32'(web), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_MU2", 32'(MU2), 32'd0);
        check("midrst_MU4", 32'(MU4), 32'd0);
        check("midrst_in_addr", 32'(in_addr), 32'd0);
        sb.delete(); dq.delete(); fq.delete();
        last_web = -1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        push_identity(0);
        start_job();
        wait_idle();

        // start held high through the done cycle: back-to-back identical job.
        push_identity(0);
        push_identity(41);
        @(negedge clk);
        t0 = ecnt;
        start = 1'b1;
        repeat (42) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // All 0xFF: 0x7F*255*4 unsigned, -1*255*4 signed.
        load_const(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push_const(exp_ff, exp_ff, exp_ff, exp_ff);
        start_job();
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
